fios_res_collector: RTL and testbench
=====================================

Name: fios_res_collector

Overview:
- Receives the word-serial 17-bit result stream from the FIOS Montgomery multiplier output (RES_o) and assembles it into a full-width value T.
- Applies the final Montgomery conditional subtraction word-serially: the result is T-p if T >= p, else T.
- Presents the reduced s*17-bit result through a valid/ready handshake. It is the consumer end of the multiplier's result stream.

Parameters:
- s, 8, number of 17-bit words per operand; must match the multiplier's s.
- WORD_W, 17, digit width in bits (radix 2^WORD_W).

Ports:
- clock_i  input  1  system clock, all state changes on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- res_valid_i  input  1  strobe; res_i carries one result beat this cycle.
- res_i  input  WORD_W  result beat. Beats 0..s-1 are words of T, least significant word first. Beat s carries the top carry in bit 0; its other bits are ignored.
- p_i  input  s*WORD_W  modulus, full width; must be held stable from the first beat until result_valid_o falls.
- result_o  output  s*WORD_W  reduced result, valid while result_valid_o = 1.
- result_valid_o  output  1  result available.
- result_ready_i  input  1  downstream accepts the result.
- busy_o  output  1  high in every state except IDLE.
- overflow_err_o  output  1  sticky; a beat arrived when it could not be accepted.

Behaviour:
- Reset (synchronous, reset_i = 1 at a clock edge):
  - State goes to IDLE; word counter, borrow and all data registers are cleared.
  - result_o = 0, result_valid_o = 0, busy_o = 0, overflow_err_o = 0.
  - Reset mid-operation abandons the transfer; no partial result is emitted.
- States: IDLE, COLLECT, SUB, OUT.
- IDLE:
  - res_valid_i = 1 stores res_i into T word 0, sets cnt = 1 and moves to COLLECT.
- COLLECT:
  - Each res_valid_i = 1 cycle with cnt < s stores res_i into T word cnt, then cnt increments.
  - The beat with cnt = s stores res_i[0] as the carry bit Tc, clears cnt and borrow, and moves to SUB.
  - Gaps (res_valid_i = 0) are allowed; the state holds.
- SUB (runs exactly s cycles, cnt = 0..s-1):
  - Each cycle: {borrow_out, D[cnt]} = T[cnt] - p[cnt] - borrow, in WORD_W+1-bit arithmetic.
  - borrow is registered; cnt increments.
  - After cycle s-1, the final borrow is combined with the carry: T >= p exactly when Tc = 1 or final borrow = 0.
  - If T >= p, result_o loads D (which wraps modulo 2^(s*WORD_W)); otherwise result_o loads T.
  - result_valid_o rises in the same edge that leaves SUB; the next state is OUT.
  - Latency: s cycles from the edge that accepts beat s to result_valid_o = 1.
- OUT:
  - result_o and result_valid_o are held stable until result_ready_i = 1.
  - On the edge with result_valid_o and result_ready_i both high, result_valid_o falls and the state goes to IDLE.
  - A new first beat is accepted from the following cycle; back-to-back transfers are not accepted in the handshake cycle.
- Overflow rule:
  - res_valid_i = 1 while in SUB or OUT sets overflow_err_o (sticky until reset).
  - The beat is dropped; the state and data are unaffected.
- No other error handling: the upstream multiplier guarantees T < 2p, so a single subtraction is sufficient.

Test Plan (s = 2, WORD_W = 17; p word0 = 0x00001, word1 = 0x00001, i.e. p = 2^17 + 1):
- T >= p: beats 0x00005, 0x00001, 0x00000 -> after 2 cycles result_valid_o = 1, result_o = 0x4 (word1 = 0, word0 = 0x00004), overflow_err_o = 0.
- T < p: beats 0x00000, 0x00001, 0x00000 -> result_o word1 = 0x00001, word0 = 0x00000 (T passed through unchanged).
- Carry set: beats 0x00000, 0x00000, 0x00001 -> result_o word1 = 0x1FFFE, word0 = 0x1FFFF (2^34 - p).
- Gapped beats plus stalled ready:
  - Stimulus: the T >= p beats with idle cycles between them; result_ready_i = 0 for 5 cycles, then 1.
  - Required: result_o = 0x4 is held for all 5 cycles, result_valid_o falls one edge after ready rises, busy_o = 0 afterwards.
- Overflow: while in OUT, pulse res_valid_i with 0x1ABCD -> overflow_err_o = 1 and result_o is unchanged. The error stays set after the handshake; only reset_i clears it.
- Reset mid-collect: after one beat, assert reset_i for one cycle, then send the T < p beats -> the result is word1 = 0x00001, word0 = 0x00000, with no residue from the aborted transfer.

Source files
------------

// File: rtl/fios_res_collector.sv
// Consumer end of the FIOS Montgomery result stream: gathers the word-serial result,
// applies the final conditional subtraction of p word by word, and hands the result out.
module fios_res_collector #(
  parameter int s      = 8,
  parameter int WORD_W = 17
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  res_valid_i,
  input  logic [WORD_W-1:0]     res_i,
  input  logic [s*WORD_W-1:0]   p_i,
  output logic [s*WORD_W-1:0]   result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  busy_o,
  output logic                  overflow_err_o
);

  localparam int CNT_W = $clog2(s + 1);
  localparam int IDX_W = (s > 1) ? $clog2(s) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, SUB, OUT} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        borrow_q, borrow_d;
  logic                        tc_q, tc_d;
  logic [s-1:0][WORD_W-1:0]    tWords_q, tWords_d;
  logic [s-1:0][WORD_W-1:0]    dWords_q, dWords_d;
  logic [s*WORD_W-1:0]         result_q, result_d;
  logic                        resultValid_q, resultValid_d;
  logic                        overflowErr_q, overflowErr_d;

  logic [s-1:0][WORD_W-1:0]    pWords;
  logic [IDX_W-1:0]            idx;
  logic [WORD_W:0]             diff;
  logic [s-1:0][WORD_W-1:0]    dFull;

  assign pWords = p_i;
  assign idx    = cnt_q[IDX_W-1:0];
  // One subtraction digit per SUB cycle; the MSB of the extended difference is the borrow out.
  assign diff   = {1'b0, tWords_q[idx]} - {1'b0, pWords[idx]} - {{WORD_W{1'b0}}, borrow_q};

  always_comb begin
    dFull      = dWords_q;
    dFull[idx] = diff[WORD_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    borrow_d      = borrow_q;
    tc_d          = tc_q;
    tWords_d      = tWords_q;
    dWords_d      = dWords_q;
    result_d      = result_q;
    resultValid_d = resultValid_q;
    overflowErr_d = overflowErr_q;

    case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          tWords_d[0] = res_i;
          cnt_d       = CNT_W'(1);
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (res_valid_i) begin
          if (cnt_q == CNT_W'(s)) begin
            tc_d     = res_i[0];
            cnt_d    = '0;
            borrow_d = 1'b0;
            state_d  = SUB;
          end else begin
            tWords_d[idx] = res_i;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end
      end
      SUB: begin
        dWords_d = dFull;
        borrow_d = diff[WORD_W];
        cnt_d    = cnt_q + CNT_W'(1);
        if (res_valid_i) overflowErr_d = 1'b1;
        // T >= p when the top carry is set or the full-width subtraction did not borrow.
        if (cnt_q == CNT_W'(s - 1)) begin
          result_d      = (tc_q || !diff[WORD_W]) ? dFull : tWords_q;
          resultValid_d = 1'b1;
          cnt_d         = '0;
          state_d       = OUT;
        end
      end
      OUT: begin
        if (res_valid_i) overflowErr_d = 1'b1;
        if (result_ready_i) begin
          resultValid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      borrow_q      <= 1'b0;
      tc_q          <= 1'b0;
      tWords_q      <= '0;
      dWords_q      <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      overflowErr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      borrow_q      <= borrow_d;
      tc_q          <= tc_d;
      tWords_q      <= tWords_d;
      dWords_q      <= dWords_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      overflowErr_q <= overflowErr_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = resultValid_q;
  assign busy_o         = (state_q != IDLE);
  assign overflow_err_o = overflowErr_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector (s = 2, 17-bit words) with a queue of expected results.
module tb_fios_res_collector;

  localparam int S = 2;
  localparam int W = 17;
  localparam logic [S*W-1:0] P = 34'h20001;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            resValid = 1'b0;
  logic [W-1:0]    resBeat = '0;
  logic [S*W-1:0]  result;
  logic            resultValid;
  logic            resultReady = 1'b0;
  logic            busy;
  logic            overflowErr;

  int              errors = 0;
  int              checks = 0;
  logic            expOvf = 1'b0;
  logic [S*W-1:0]  expQ[$];

  fios_res_collector #(.s(S), .WORD_W(W)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .res_valid_i    (resValid),
    .res_i          (resBeat),
    .p_i            (P),
    .result_o       (result),
    .result_valid_o (resultValid),
    .result_ready_i (resultReady),
    .busy_o         (busy),
    .overflow_err_o (overflowErr)
  );

  always #5 clock = ~clock;

  // Hard stop in case a directed step somehow never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [S*W-1:0] model(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                           input logic [W-1:0] w2);
    logic [S*W:0] t;
    logic [S*W:0] pe;
    t  = {w2[0], w1, w0};
    pe = {1'b0, P};
    if (t >= pe) return (S*W)'(t - pe);
    return t[S*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the beat across exactly one rising edge.
  task automatic sendBeat(input logic [W-1:0] b);
    resValid = 1'b1;
    resBeat  = b;
    @(negedge clock);
    resValid = 1'b0;
    resBeat  = '0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input logic [W-1:0] w2, input int gap);
    int lat;
    expQ.push_back(model(w0, w1, w2));
    sendBeat(w0);
    repeat (gap) @(negedge clock);
    sendBeat(w1);
    check("busy_collect", 64'(busy), 64'd1);
    repeat (gap) @(negedge clock);
    sendBeat(w2);
    lat = 0;
    while (!resultValid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
  endtask

  task automatic checkOutput(input string tag);
    logic [S*W-1:0] e;
    e = '0;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      check(tag, 64'(result), 64'(e));
    end
    check({tag, "_valid"}, 64'(resultValid), 64'd1);
    check({tag, "_ovf"}, 64'(overflowErr), 64'(expOvf));
  endtask

  task automatic handshake(input string tag);
    resultReady = 1'b1;
    @(negedge clock);
    resultReady = 1'b0;
    check({tag, "_valid_fall"}, 64'(resultValid), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_result", 64'(result), 64'd0);
    check("reset_valid", 64'(resultValid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ovf", 64'(overflowErr), 64'd0);

    applyStimulus(17'h00005, 17'h00001, 17'h00000, 0);
    checkOutput("ge_p");
    handshake("ge_p");

    applyStimulus(17'h00000, 17'h00001, 17'h00000, 0);
    checkOutput("lt_p");
    check("lt_p_const", 64'(result), 64'h20000);
    handshake("lt_p");

    applyStimulus(17'h00000, 17'h00000, 17'h00001, 0);
    checkOutput("carry");
    check("carry_const", 64'(result), 64'h3FFFDFFFF);
    handshake("carry");

    applyStimulus(17'h00005, 17'h00001, 17'h00000, 2);
    checkOutput("gapped");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_hold", 64'(result), 64'h4);
      check("stall_valid", 64'(resultValid), 64'd1);
    end
    handshake("stall");

    applyStimulus(17'h00005, 17'h00001, 17'h00000, 0);
    sendBeat(17'h1ABCD);
    expOvf = 1'b1;
    checkOutput("ovf");
    check("ovf_result_kept", 64'(result), 64'h4);
    handshake("ovf");
    check("ovf_sticky", 64'(overflowErr), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expOvf = 1'b0;
    check("ovf_cleared", 64'(overflowErr), 64'd0);

    sendBeat(17'h1FFFF);
    check("abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_no_valid", 64'(resultValid), 64'd0);
    applyStimulus(17'h00000, 17'h00001, 17'h00000, 0);
    checkOutput("after_abort");
    check("after_abort_const", 64'(result), 64'h20000);
    handshake("after_abort");

    check("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
